// File: rtl/serdes_pkg.sv
// Shared types and constants for the word serializer path.
package serdes_pkg;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;
  localparam int DIV_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: tick is high for one cycle every CLK_DIV cycles while run is high.
// load restarts the period so the first tick lands CLK_DIV cycles after the load edge.
module bit_tick_gen import serdes_pkg::*; #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic resetb,
  input  logic load,
  input  logic run,
  output logic tick
);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  assign tick = run && (div_q == '0);

  always_comb begin
    div_d = div_q;
    if (load || tick) begin
      div_d = RELOAD;
    end else if (run) begin
      div_d = div_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial word transmitter, MSB first, one strobe per bit every CLK_DIV cycles.
// First strobe CLK_DIV cycles after accept; a new word is taken in IDLE or on the last strobe.
module word_serializer #(
  parameter int CLK_DIV = 1,
  parameter int WORD_W  = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              ser_o,
  output logic              ser_en_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int CNT_W = serdes_pkg::CNT_W;

  if (CLK_DIV < 1 || CLK_DIV > 256) begin : g_bad_clk_div
    $error("word_serializer: CLK_DIV must be within 1..256");
  end
  if (WORD_W != serdes_pkg::WORD_W) begin : g_bad_word_w
    $error("word_serializer: WORD_W must be 16");
  end

  serdes_pkg::state_t state_q;
  logic [WORD_W-1:0]  shreg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_en_q;
  logic               strobe;
  logic               last;
  logic               accept;

  bit_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .resetb (resetb),
    .load   (accept),
    .run    (busy_o),
    .tick   (strobe)
  );

  assign busy_o   = (state_q == serdes_pkg::SHIFT);
  assign last     = strobe && (cnt_q == CNT_W'(WORD_W - 1));
  // ready_en_q keeps ready_o low until the first edge after reset release.
  assign ready_o  = ready_en_q && ((state_q == serdes_pkg::IDLE) || last);
  assign accept   = valid_i && ready_o;
  assign ser_en_o = strobe;
  assign done_o   = last;
  assign ser_o    = busy_o && shreg_q[WORD_W-1];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= serdes_pkg::IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        shreg_q <= data_i;
        cnt_q   <= '0;
        state_q <= serdes_pkg::SHIFT;
      end else if (strobe) begin
        shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last) begin
          state_q <= serdes_pkg::IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: four instances (CLK_DIV 1,3,4,7), scoreboard of expected bits/words.
module tb_word_serializer;
  localparam int NI = 4;

  function automatic int div_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 7;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        resetb;
  logic [15:0] data   [NI];
  logic        valid  [NI];
  logic        rdy    [NI];
  logic        ser    [NI];
  logic        ser_en [NI];
  logic        busy   [NI];
  logic        done   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    word_serializer #(
      .CLK_DIV (div_of(g)),
      .WORD_W  (16)
    ) u_dut (
      .clk      (clk),
      .resetb   (resetb),
      .data_i   (data[g]),
      .valid_i  (valid[g]),
      .ready_o  (rdy[g]),
      .ser_o    (ser[g]),
      .ser_en_o (ser_en[g]),
      .busy_o   (busy[g]),
      .done_o   (done[g])
    );
  end

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard state for the instance currently under test.
  bit          bit_q[$];
  logic [15:0] word_q[$];
  int          act = 0;
  int          bitcnt = 0;
  bit          pend = 0;
  logic [15:0] pend_w = '0;
  logic [15:0] rx = '0;

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bit_q.push_back(w[i]);
    word_q.push_back(w);
  endtask

  // Receiver model: 16-bit serial-in shift register, first bit in ends in bit 15.
  always @(posedge clk) begin
    if (ser_en[act]) rx <= {rx[14:0], ser[act]};
  end

  always @(negedge clk) begin
    bit b;
    if (!resetb) begin
      bit_q.delete();
      word_q.delete();
      bitcnt = 0;
      pend   = 0;
    end else begin
      if (pend) begin
        chk("rx_word", rx, pend_w);
        pend = 0;
      end
      if (ser_en[act]) begin
        chk("strobe_expected", bit_q.size() != 0, 1);
        if (bit_q.size() != 0) begin
          b = bit_q.pop_front();
          chk("ser_bit", ser[act], b);
          chk("done_at_strobe", done[act], bitcnt == 15);
          if (bitcnt == 15) begin
            pend   = 1;
            pend_w = word_q.pop_front();
          end
          bitcnt = (bitcnt + 1) % 16;
        end
      end else begin
        chk("done_no_strobe", done[act], 0);
      end
    end
  end

  task automatic offer(input int k, input logic [15:0] w, output int waited);
    data[k]  = w;
    valid[k] = 1'b1;
    waited   = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rdy[k]) begin
        push_word(w);
        waited = i;
        @(posedge clk);
        #1;
        return;
      end
    end
    n_chk++;
    n_bad++;
    $display("FAIL accept_timeout: ready_o stayed 0 want 1 at %0t", $time);
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy[k]) begin
        repeat (2) @(posedge clk);
        #1;
        return;
      end
    end
    n_chk++;
    n_bad++;
    $display("FAIL idle_timeout: busy_o stayed 1 want 0 at %0t", $time);
  endtask

  typedef struct {
    int          k;
    logic [15:0] w;
    int          first;
    int          last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int wt;
    int first;
    int lastc;
    int ns;
    int k;
    logic [15:0] w;

    vecs[0] = '{k: 0, w: 16'hA5C3, first: 1, last: 16};
    vecs[1] = '{k: 1, w: 16'h0F0F, first: 3, last: 48};
    vecs[2] = '{k: 2, w: 16'h8001, first: 4, last: 64};
    vecs[3] = '{k: 3, w: 16'h7FFE, first: 7, last: 112};
    vecs[4] = '{k: 2, w: 16'hFFFF, first: 4, last: 64};

    resetb = 1'b0;
    for (int i = 0; i < NI; i++) begin
      data[i]  = '0;
      valid[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_ser", ser[i], 0);
      chk("reset_ser_en", ser_en[i], 0);
      chk("reset_busy", busy[i], 0);
      chk("reset_done", done[i], 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk("ready_after_reset", rdy[i], 1);

    // Single words: latency to first strobe, done position, ready pattern, stable bit periods.
    for (int v = 0; v < 5; v++) begin
      k     = vecs[v].k;
      w     = vecs[v].w;
      act   = k;
      first = -1;
      lastc = -1;
      offer(k, w, wt);
      valid[k] = 1'b0;
      for (int c = 1; c <= vecs[v].last + 2; c++) begin
        @(negedge clk);
        if (ser_en[k] && first < 0) first = c;
        if (done[k]) lastc = c;
        if (c <= vecs[v].last) begin
          chk("ready_in_word", rdy[k], c == vecs[v].last);
          chk("busy_in_word", busy[k], 1);
          chk("ser_stable", ser[k], w[15 - (c - 1) / div_of(k)]);
        end else begin
          chk("busy_after_word", busy[k], 0);
          chk("ser_idle", ser[k], 0);
        end
        @(posedge clk);
        #1;
      end
      chk("first_strobe_cycle", first, vecs[v].first);
      chk("done_cycle", lastc, vecs[v].last);
      wait_idle(k);
    end

    // Back-to-back at CLK_DIV=1 with valid held: 32 strobes, no gap.
    act = 0;
    offer(0, 16'hFFFF, wt);
    data[0] = 16'h0001;
    for (int c = 1; c <= 40; c++) begin
      bit acc;
      @(negedge clk);
      chk("b2b_strobe", ser_en[0], c <= 32);
      chk("b2b_done", done[0], (c == 16) || (c == 32));
      acc = rdy[0] && valid[0];
      if (acc) push_word(16'h0001);
      @(posedge clk);
      #1;
      if (acc) valid[0] = 1'b0;
    end
    wait_idle(0);

    // Input noise mid-word at CLK_DIV=3; next word only taken on the last strobe.
    act = 1;
    offer(1, 16'h3C5A, wt);
    for (int i = 0; i < 40; i++) begin
      data[1]  = 16'($urandom);
      valid[1] = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("ready_midword", rdy[1], 0);
      @(posedge clk);
      #1;
    end
    offer(1, 16'hC3A5, wt);
    chk("accept_cycle", 41 + wt, 48);
    valid[1] = 1'b0;
    wait_idle(1);

    // Reset after the 7th strobe aborts the word; the next word goes out intact.
    act = 0;
    ns  = 0;
    offer(0, 16'h1234, wt);
    valid[0] = 1'b0;
    for (int i = 0; i < 100 && ns < 7; i++) begin
      @(negedge clk);
      if (ser_en[0]) ns++;
      @(posedge clk);
      #1;
    end
    resetb = 1'b0;
    #1;
    chk("abort_ser", ser[0], 0);
    chk("abort_ser_en", ser_en[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_abort", rdy[0], 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_strobe_after_abort", ser_en[0], 0);
      chk("idle_after_abort", busy[0], 0);
    end
    @(posedge clk);
    #1;
    offer(0, 16'h00FF, wt);
    valid[0] = 1'b0;
    wait_idle(0);

    // Random loopback: blocks of back-to-back words on CLK_DIV 1, 3 or 7.
    for (int blk = 0; blk < 100; blk++) begin
      int kk;
      kk  = $urandom_range(0, 2);
      k   = (kk == 0) ? 0 : (kk == 1) ? 1 : 3;
      act = k;
      for (int j = 0; j < 10; j++) offer(k, 16'($urandom), wt);
      valid[k] = 1'b0;
      wait_idle(k);
    end
    chk("scoreboard_drained", bit_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
